// File: rtl/rv_fetch_pc.sv
// rv_fetch_pc -- instruction fetch front end.
// Owns the fetch PC and issues one request at a time on the instruction bus.
// Each fetched word is held in a registered output buffer until decode takes
// it. Redirects from execute override everything except reset.
// Define RV_BRANCH_PRED_EN to build the direct-mapped BTB. Without it the
// next PC is always sequential and the i_bp_* inputs are unused.
module rv_fetch_pc #(
   parameter int unsigned IADDR_SPACE_BITS = 32,
   parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
   parameter int unsigned BTB_ENTRIES      = 8
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_stall,
   input  logic                        i_redirect,
   input  logic [IADDR_SPACE_BITS-1:0] i_redirect_pc,
   input  logic                        i_bp_update,
   input  logic [IADDR_SPACE_BITS-1:0] i_bp_pc,
   input  logic [IADDR_SPACE_BITS-1:0] i_bp_target,
   input  logic                        i_bp_taken,
   output logic                        o_ibus_req,
   output logic [IADDR_SPACE_BITS-1:0] o_ibus_addr,
   input  logic                        i_ibus_ack,
   input  logic [31:0]                 i_ibus_data,
   output logic                        o_valid,
   output logic [31:0]                 o_instr,
   output logic [IADDR_SPACE_BITS-1:0] o_pc,
   output logic [IADDR_SPACE_BITS-1:0] o_pc_next,
   output logic                        o_branch_pred
);

   localparam int unsigned   AW          = IADDR_SPACE_BITS;
   localparam int unsigned   IDX_W       = $clog2(BTB_ENTRIES);
   localparam int unsigned   TAG_W       = AW - 2 - IDX_W;
   localparam logic [AW-1:0] RST_PC      = RESET_ADDR[AW-1:0];
   localparam logic [AW-1:0] RST_PC_NEXT = RST_PC + AW'(4);
   localparam logic [31:0]   NOP_INSTR   = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } state_e;

   state_e        state_q;
   logic [AW-1:0] fetch_pc_q;
   logic [AW-1:0] ibus_addr_q;
   logic          ibus_req_q;
   logic          valid_q;
   logic [31:0]   instr_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_next_q;
   logic          branch_pred_q;

   logic [AW-1:0] redirect_pc;
   logic [AW-1:0] seq_pc;
   logic [AW-1:0] pred_pc;
   logic [AW-1:0] btb_target;
   logic          btb_hit;
   logic          unused_bits;

   assign redirect_pc = {i_redirect_pc[AW-1:2], 2'b00};
   assign seq_pc      = fetch_pc_q + AW'(4);
   assign pred_pc     = btb_hit ? btb_target : seq_pc;

`ifdef RV_BRANCH_PRED_EN
   logic [BTB_ENTRIES-1:0] btb_valid_q;
   logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
   logic [AW-1:0]          btb_target_q [BTB_ENTRIES];
   logic [IDX_W-1:0]       lkp_idx;
   logic [TAG_W-1:0]       lkp_tag;
   logic [IDX_W-1:0]       upd_idx;
   logic [TAG_W-1:0]       upd_tag;

   assign lkp_idx     = fetch_pc_q[2 +: IDX_W];
   assign lkp_tag     = fetch_pc_q[AW-1 -: TAG_W];
   assign upd_idx     = i_bp_pc[2 +: IDX_W];
   assign upd_tag     = i_bp_pc[AW-1 -: TAG_W];
   assign btb_hit     = btb_valid_q[lkp_idx] && (btb_tag_q[lkp_idx] == lkp_tag);
   assign btb_target  = btb_target_q[lkp_idx];
   assign unused_bits = ^{i_redirect_pc[1:0], i_bp_pc[1:0], i_bp_target[1:0]};

   // BTB valid bits: set on taken training, cleared on not-taken tag match
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         btb_valid_q <= '0;
      end else if (i_bp_update) begin
         if (i_bp_taken) begin
            btb_valid_q[upd_idx] <= 1'b1;
         end else if (btb_tag_q[upd_idx] == upd_tag) begin
            btb_valid_q[upd_idx] <= 1'b0;
         end
      end
   end

   // BTB payload written on taken training; lookups this cycle see old data
   always_ff @(posedge i_clk) begin
      // NOTE: tag/target arrays are not reset; a cleared valid bit makes their contents irrelevant.
      if (!i_reset && i_bp_update && i_bp_taken) begin
         btb_tag_q[upd_idx]    <= upd_tag;
         btb_target_q[upd_idx] <= {i_bp_target[AW-1:2], 2'b00};
      end
   end
`else
   assign btb_hit     = 1'b0;
   assign btb_target  = '0;
   assign unused_bits = ^{i_redirect_pc[1:0], i_bp_update, i_bp_pc, i_bp_target, i_bp_taken};
`endif

   // Fetch sequencer: state, bus request/address and output buffer
   always_ff @(posedge i_clk) begin
      // NOTE: every register here uses non-blocking assignment so all of them see pre-edge values.
      if (i_reset) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RST_PC;
         ibus_req_q    <= 1'b0;
         ibus_addr_q   <= RST_PC;
         valid_q       <= 1'b0;
         instr_q       <= NOP_INSTR;
         pc_q          <= RST_PC;
         pc_next_q     <= RST_PC_NEXT;
         branch_pred_q <= 1'b0;
      end else if (i_redirect) begin
         valid_q    <= 1'b0;
         fetch_pc_q <= redirect_pc;
         if ((state_q == REQ || state_q == DISCARD) && !i_ibus_ack) begin
            // Request still in flight: keep it stable and drop its response later
            state_q <= DISCARD;
         end else begin
            state_q     <= REQ;
            ibus_req_q  <= 1'b1;
            ibus_addr_q <= redirect_pc;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               state_q     <= REQ;
               ibus_req_q  <= 1'b1;
               ibus_addr_q <= fetch_pc_q;
            end
            REQ: begin
               if (i_ibus_ack) begin
                  state_q       <= HOLD;
                  ibus_req_q    <= 1'b0;
                  valid_q       <= 1'b1;
                  instr_q       <= i_ibus_data;
                  pc_q          <= fetch_pc_q;
                  pc_next_q     <= pred_pc;
                  branch_pred_q <= btb_hit;
                  fetch_pc_q    <= pred_pc;
               end
            end
            HOLD: begin
               if (!i_stall) begin
                  state_q     <= REQ;
                  valid_q     <= 1'b0;
                  ibus_req_q  <= 1'b1;
                  ibus_addr_q <= fetch_pc_q;
               end
            end
            DISCARD: begin
               if (i_ibus_ack) begin
                  state_q     <= REQ;
                  ibus_addr_q <= fetch_pc_q;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_ibus_req    = ibus_req_q;
   assign o_ibus_addr   = ibus_addr_q;
   assign o_valid       = valid_q;
   assign o_instr       = instr_q;
   assign o_pc          = pc_q;
   assign o_pc_next     = pc_next_q;
   assign o_branch_pred = branch_pred_q;

endmodule
